// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline stage register; optional statistics via PIPE_REG_STATS_EN.
// Latency 1 cycle; IN_READY registered (low only in SKID), BUSYWAIT freezes, FLUSH empties.
module pipe_skid_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic [CTRL_WIDTH-1:0] IN_CTRL,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [CTRL_WIDTH-1:0] OUT_CTRL,
    input  logic                  BUSYWAIT,
    input  logic                  FLUSH,
    output logic [CNT_WIDTH-1:0]  STALL_CNT,
    output logic [CNT_WIDTH-1:0]  BUBBLE_CNT
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic                  out_valid;
    logic                  in_fire, out_fire;

    assign out_valid = (state_q == ST_FULL) || (state_q == ST_SKID);
    assign in_fire   = IN_VALID & in_ready_q & ~BUSYWAIT;
    assign out_fire  = out_valid & OUT_READY & ~BUSYWAIT;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d     = ST_FULL;
                    main_data_d = IN_DATA;
                    main_ctrl_d = IN_CTRL;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    main_data_d = IN_DATA;
                    main_ctrl_d = IN_CTRL;
                end else if (in_fire) begin
                    state_d     = ST_SKID;
                    skid_data_d = IN_DATA;
                    skid_ctrl_d = IN_CTRL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    state_d     = ST_FULL;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush overrides everything, including a frozen stage and a same-edge input beat.
        if (FLUSH) begin
            state_d     = ST_EMPTY;
            main_data_d = main_data_q;
            skid_data_d = skid_data_q;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end
    end

    assign in_ready_d = (state_d != ST_SKID);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid;
    assign OUT_DATA  = main_data_q;
    assign OUT_CTRL  = out_valid ? main_ctrl_q : '0;

`ifdef PIPE_REG_STATS_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, bubble_cnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (out_valid && (!OUT_READY || BUSYWAIT) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (!out_valid && (bubble_cnt_q != '1))
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign STALL_CNT  = stall_cnt_q;
    assign BUBBLE_CNT = bubble_cnt_q;
`else
    assign STALL_CNT  = '0;
    assign BUBBLE_CNT = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       IN_VALID, IN_READY, OUT_VALID, OUT_READY, BUSYWAIT, FLUSH;
    logic [31:0] IN_DATA, OUT_DATA;
    logic [7:0]  IN_CTRL, OUT_CTRL;
    logic [3:0]  STALL_CNT, BUBBLE_CNT;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef PIPE_REG_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    pipe_skid_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .CNT_WIDTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_CTRL(OUT_CTRL),
        .BUSYWAIT(BUSYWAIT), .FLUSH(FLUSH),
        .STALL_CNT(STALL_CNT), .BUBBLE_CNT(BUBBLE_CNT)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge and settle 1 ns after it before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        IN_VALID  = 1'b0;
        IN_DATA   = '0;
        IN_CTRL   = '0;
        OUT_READY = 1'b0;
        BUSYWAIT  = 1'b0;
        FLUSH     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1; IN_DATA = 32'd11; IN_CTRL = 8'h3c;
        step();
        IN_DATA = 32'd23;
        #2;
        RESET = 1'b0;
        #1;
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0h want 0", OUT_VALID); end
        n_cmp++; if (OUT_DATA !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", OUT_DATA); end
        n_cmp++; if (OUT_CTRL !== 8'd0) begin n_fail++; $display("FAIL reset_out_ctrl got %0h want 0", OUT_CTRL); end
        n_cmp++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0h want 1", IN_READY); end
        n_cmp++; if (STALL_CNT !== 4'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", STALL_CNT); end
        n_cmp++; if (BUBBLE_CNT !== 4'd0) begin n_fail++; $display("FAIL reset_bubble_cnt got %0d want 0", BUBBLE_CNT); end
        idle_inputs();
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_streaming();
        logic [31:0] vec [3];
        vec[0] = 32'd45; vec[1] = 32'd56; vec[2] = 32'd35;
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IN_VALID = 1'b1; IN_DATA = vec[i]; IN_CTRL = 8'(i + 1);
            step();
            n_cmp++; if (OUT_DATA !== vec[i]) begin n_fail++; $display("FAIL stream_data[%0d] got %0d want %0d", i, OUT_DATA, vec[i]); end
            n_cmp++; if (OUT_CTRL !== 8'(i + 1)) begin n_fail++; $display("FAIL stream_ctrl[%0d] got %0h want %0h", i, OUT_CTRL, i + 1); end
            n_cmp++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %0h want 1", i, IN_READY); end
        end
        IN_VALID = 1'b0;
        step();
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid got %0h want 0", OUT_VALID); end
        n_cmp++; if (OUT_CTRL !== 8'd0) begin n_fail++; $display("FAIL stream_drain_ctrl got %0h want 0", OUT_CTRL); end
    endtask

    task automatic test_skid();
        do_reset();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 32'd45; IN_CTRL = 8'h11;
        step();
        n_cmp++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL skid_full_in_ready got %0h want 1", IN_READY); end
        IN_DATA = 32'd56; IN_CTRL = 8'h22;
        step();
        n_cmp++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL skid_in_ready_low got %0h want 0", IN_READY); end
        n_cmp++; if (OUT_DATA !== 32'd45) begin n_fail++; $display("FAIL skid_head_hold got %0d want 45", OUT_DATA); end
        IN_DATA = 32'd77; IN_CTRL = 8'h77;
        step();
        n_cmp++; if (OUT_DATA !== 32'd45) begin n_fail++; $display("FAIL skid_head_hold2 got %0d want 45", OUT_DATA); end
        n_cmp++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL skid_in_ready_low2 got %0h want 0", IN_READY); end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        step();
        n_cmp++; if (OUT_DATA !== 32'd56) begin n_fail++; $display("FAIL skid_second_data got %0d want 56", OUT_DATA); end
        n_cmp++; if (OUT_CTRL !== 8'h22) begin n_fail++; $display("FAIL skid_second_ctrl got %0h want 22", OUT_CTRL); end
        n_cmp++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL skid_in_ready_back got %0h want 1", IN_READY); end
        step();
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL skid_drained_valid got %0h want 0", OUT_VALID); end
    endtask

    task automatic test_busywait();
        logic [3:0] exp_stall;
        do_reset();
        OUT_READY = 1'b1;
        IN_VALID = 1'b1; IN_DATA = 32'd15; IN_CTRL = 8'h0f;
        step();
        IN_DATA = 32'd10; IN_CTRL = 8'h0a;
        BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (OUT_DATA !== 32'd15) begin n_fail++; $display("FAIL busy_hold_data[%0d] got %0d want 15", i, OUT_DATA); end
        end
        exp_stall = STATS ? 4'd3 : 4'd0;
        n_cmp++; if (STALL_CNT !== exp_stall) begin n_fail++; $display("FAIL busy_stall_cnt got %0d want %0d", STALL_CNT, exp_stall); end
        n_cmp++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL busy_in_ready got %0h want 1", IN_READY); end
        BUSYWAIT = 1'b0;
        IN_VALID = 1'b0;
        step();
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL busy_release_valid got %0h want 0", OUT_VALID); end
        n_cmp++; if (STALL_CNT !== exp_stall) begin n_fail++; $display("FAIL busy_stall_after got %0d want %0d", STALL_CNT, exp_stall); end
    endtask

    task automatic test_flush();
        do_reset();
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 32'd20; IN_CTRL = 8'h81;
        step();
        IN_DATA = 32'd40;
        step();
        n_cmp++; if (OUT_CTRL !== 8'h81) begin n_fail++; $display("FAIL flush_pre_ctrl got %0h want 81", OUT_CTRL); end
        n_cmp++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL flush_pre_in_ready got %0h want 0", IN_READY); end
        FLUSH = 1'b1; BUSYWAIT = 1'b1;
        IN_DATA = 32'd99; IN_CTRL = 8'hee;
        step();
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0h want 0", OUT_VALID); end
        n_cmp++; if (OUT_CTRL !== 8'd0) begin n_fail++; $display("FAIL flush_ctrl got %0h want 0", OUT_CTRL); end
        n_cmp++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %0h want 1", IN_READY); end
        FLUSH = 1'b0; BUSYWAIT = 1'b0; OUT_READY = 1'b1;
        IN_DATA = 32'd50; IN_CTRL = 8'h05;
        step();
        n_cmp++; if (OUT_DATA !== 32'd50) begin n_fail++; $display("FAIL flush_next_data got %0d want 50", OUT_DATA); end
        n_cmp++; if (OUT_CTRL !== 8'h05) begin n_fail++; $display("FAIL flush_next_ctrl got %0h want 05", OUT_CTRL); end
        IN_VALID = 1'b0;
        step();
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL flush_alone_valid got %0h want 0", OUT_VALID); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_bubble;
        do_reset();
        for (int i = 0; i < 20; i++) step();
        exp_bubble = STATS ? 4'd15 : 4'd0;
        n_cmp++; if (BUBBLE_CNT !== exp_bubble) begin n_fail++; $display("FAIL sat_bubble_cnt got %0d want %0d", BUBBLE_CNT, exp_bubble); end
        n_cmp++; if (STALL_CNT !== 4'd0) begin n_fail++; $display("FAIL sat_stall_cnt got %0d want 0", STALL_CNT); end
    endtask

    initial begin
        RESET = 1'b0;
        idle_inputs();
        test_reset();
        test_streaming();
        test_skid();
        test_busywait();
        test_flush();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

- Parametrised, elastic successor to the fixed-field inter-stage pipeline registers.
- Two-entry skid-buffered stage register carrying a generic data payload and a control payload between two pipeline stages.
- Uses a valid/ready handshake, a global `BUSYWAIT` freeze and a synchronous `FLUSH`; flushing inserts a bubble with control zeroed.
- `IN_READY` is registered, breaking the combinational ready path between stages so any IF/ID, ID/EX, EX/MEM or MEM/WB boundary can be retimed.

## Interface
- `DATA_WIDTH`, 32: payload width (PC, ALU result, immediate, memory data, concatenated by the parent).
- `CTRL_WIDTH`, 8: control payload width (write enables, WB select, rd); forced 0 on bubbles.
- `CNT_WIDTH`, 16: width of statistics counters.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RESET` in 1: reset, asynchronous, active-low.
- `IN_VALID` in 1: upstream beat valid.
- `IN_READY` out 1: registered; stage can accept a beat.
- `IN_DATA` in `DATA_WIDTH`: upstream payload.
- `IN_CTRL` in `CTRL_WIDTH`: upstream control.
- `OUT_VALID` out 1: downstream beat valid.
- `OUT_READY` in 1: downstream accepts.
- `OUT_DATA` out `DATA_WIDTH`: head payload.
- `OUT_CTRL` out `CTRL_WIDTH`: head control; 0 whenever `OUT_VALID`=0.
- `BUSYWAIT` in 1: memory stall; freezes all state.
- `FLUSH` in 1: synchronous kill of all held beats.
- `STALL_CNT` out `CNT_WIDTH`: cycles with `OUT_VALID`=1 and not fired.
- `BUBBLE_CNT` out `CNT_WIDTH`: cycles with `OUT_VALID`=0.

## Operation
- Internal fire conditions:
  - in_fire = `IN_VALID` & `IN_READY` & ~`BUSYWAIT`.
  - out_fire = `OUT_VALID` & `OUT_READY` & ~`BUSYWAIT`.
- States: EMPTY (no beat), FULL (main register valid), SKID (main and skid valid).
- EMPTY: in_fire → FULL, main ← input.
- FULL:
  - in_fire & out_fire → FULL, main ← input.
  - in_fire only → SKID, skid ← input.
  - out_fire only → EMPTY.
  - Neither → hold.
- SKID: out_fire → FULL, main ← skid; otherwise hold. No in_fire is possible since `IN_READY`=0.
- `IN_READY` = 0 exactly in SKID, registered from next-state.
- `OUT_VALID` = 1 in FULL and SKID.
- `BUSYWAIT`=1: state, data and `IN_READY` hold regardless of handshakes.
- `FLUSH`=1 at an edge: state → EMPTY, `IN_READY` → 1, stored control cleared to 0. Data registers may hold stale values.
  - `FLUSH` has priority over `BUSYWAIT` and over a simultaneous in_fire; that input beat is dropped.
- Reset (asserted low, asynchronous):
  - State EMPTY; `IN_READY`=1; `OUT_VALID`=0.
  - `OUT_DATA`=0, `OUT_CTRL`=0, skid contents 0.
  - `STALL_CNT`=0, `BUBBLE_CNT`=0.
- Reset mid-transfer discards all held beats immediately, without waiting for a clock edge.

## Timing
- Latency: 1 cycle; a beat accepted at edge N appears on `OUT_*` after edge N.
- Throughput: 1 beat/cycle sustained while `OUT_READY`=1.
- Ordering: strict FIFO, no beat lost or duplicated except by `FLUSH` or reset.
- After `OUT_READY` deasserts, at most one further beat is accepted (into skid). `IN_READY` falls the following cycle.
- Once `OUT_READY` reasserts, `IN_READY` returns 1 one edge after the skid drains.
- No combinational path from `OUT_READY` to `IN_READY`.
- `OUT_DATA` and `OUT_CTRL` are stable while `OUT_VALID`=1 and not fired.

## Configuration
- `PIPE_REG_STATS_EN` defined:
  - `STALL_CNT` increments each edge with `OUT_VALID`=1 & (~`OUT_READY` | `BUSYWAIT`).
  - `BUBBLE_CNT` increments each edge with `OUT_VALID`=0.
  - Both saturate at all-ones and clear only on reset; `FLUSH` does not clear them.
- `PIPE_REG_STATS_EN` undefined: counters are not built; both ports are tied to 0 and the port list is unchanged.

## Test plan
- Reset: drive `RESET`=0 mid-cycle with `IN_VALID`=1, `IN_DATA`=23 → immediately `OUT_VALID`=0, `OUT_DATA`=0, `OUT_CTRL`=0, `IN_READY`=1; counters 0.
- Streaming: `OUT_READY`=1, push `IN_DATA` 45, 56, 35 on consecutive edges → `OUT_DATA` shows 45, 56, 35 one cycle later each; `IN_READY` stays 1.
- Skid:
  - Hold `OUT_READY`=0 after 45 is held, push 56 → `IN_READY`=0 next cycle; `OUT_DATA` stays 45.
  - Raise `OUT_READY` → 45 then 56 emerge; `IN_READY`=1 after the skid drains.
- BUSYWAIT: with 15 held, `BUSYWAIT`=1 for 3 cycles, `OUT_READY`=1, `IN_DATA`=10 → `OUT_DATA` stays 15; `STALL_CNT` +3 with `PIPE_REG_STATS_EN`, stays 0 without.
- Flush: SKID with 20, 40 and `IN_CTRL`=8'h81, assert `FLUSH`=1 with `BUSYWAIT`=1 → next edge `OUT_VALID`=0, `OUT_CTRL`=0, `IN_READY`=1; the next pushed beat 50 appears alone.
- Saturation: with `CNT_WIDTH`=4 and `PIPE_REG_STATS_EN`, 20 idle cycles → `BUBBLE_CNT`=15.
